updown_count_pair: RTL and testbench
====================================

Name: updown_count_pair

Overview:
- Parametrised successor to the fixed 4-bit up/down counter pair.
- Holds two modulo counters. One always counts up and the other always counts down.
- A Swap edge exchanges the two values, so each count continues from where the other left off, in the opposite direction.
- Adds configurable width, modulus and step, synchronous load/clear, wrap pulses and a swap-state flag. Used as a timebase/sequence source in the exercise designs.

Parameters:
- WIDTH, 4: bit width of both counters.
- MAX_COUNT, 15: highest count value. Counters wrap modulo MAX_COUNT+1. Must be 1 <= MAX_COUNT <= 2^WIDTH-1.
- STEP, 1: increment/decrement per enabled cycle. Must be 1 <= STEP <= MAX_COUNT.

Ports:
- Clock  input  1  rising-edge clock; all state changes on it.
- ResetN  input  1  synchronous, active-low reset.
- Enable  input  1  count enable, level-sensitive.
- Swap  input  1  exchange request, rising-edge detected internally.
- Clear  input  1  synchronous clear to reset values (not a reset of Swapped).
- Load  input  1  synchronous load of both counters.
- LoadValue  input  WIDTH  value for Load.
- UpCountS  output  WIDTH  up-counting register.
- DownCountS  output  WIDTH  down-counting register.
- WrapUp  output  1  one-cycle pulse: UpCountS wrapped on the last update.
- WrapDown  output  1  one-cycle pulse: DownCountS wrapped on the last update.
- Swapped  output  1  toggles on every accepted swap.

Behaviour:
- One clock domain; reset is synchronous and active-low. ResetN sampled low at a rising Clock edge forces:
  - UpCountS=0, DownCountS=MAX_COUNT, WrapUp=0, WrapDown=0, Swapped=0.
  - Internal SwapQ=1, so a Swap held high across reset release is not an edge.
- Swap edge detect: SwapEdge = Swap & ~SwapQ; SwapQ <= Swap every cycle out of reset.
- Arithmetic is done in WIDTH+1 bits, with N = MAX_COUNT+1:
  - inc(x) = x+STEP if x+STEP <= MAX_COUNT, else x+STEP-N (wrap).
  - dec(x) = x-STEP if x >= STEP, else x+N-STEP (wrap).
- Priority per cycle (highest first):
  - ResetN low: reset values as above.
  - Clear: UpCountS=0, DownCountS=MAX_COUNT. Swapped is held. Any SwapEdge that cycle is discarded.
  - Load: both counters <= min(LoadValue, MAX_COUNT). SwapEdge is discarded.
  - SwapEdge with Enable=1: UpCountS <= inc(DownCountS), DownCountS <= dec(UpCountS), Swapped toggles.
  - SwapEdge with Enable=0: UpCountS <= DownCountS, DownCountS <= UpCountS, Swapped toggles.
  - Enable=1: UpCountS <= inc(UpCountS), DownCountS <= dec(DownCountS).
  - Otherwise: hold.
- WrapUp/WrapDown:
  - Registered. Asserted in the cycle after the update where the wrap branch was taken.
  - Cleared on every other cycle, including Clear, Load and hold cycles.
- Latency: outputs change one Clock edge after the qualifying inputs are sampled. No combinational path from inputs to outputs.
- Swap held high for many cycles gives exactly one swap. A new swap needs Swap low for at least one sampled cycle.
- Enable dropping mid-sequence holds values with no drift. Re-enable resumes from the held values.
- Reset mid-operation takes effect at the next edge regardless of Enable/Swap/Load.

Test Plan (WIDTH=4, MAX_COUNT=9, STEP=1 unless noted):
- Reset and count: ResetN low 2 cycles, then Enable=1 for 12 cycles.
  - After reset: Up=0, Down=9.
  - Up runs 1..9,0,1,2 with WrapUp one cycle after the 9->0 step.
  - Down runs 8..0,9,8,7 with WrapDown one cycle after the 0->9 step.
- Swap with Enable: Up=3, Down=6, Enable=1, Swap 0->1 and held 5 cycles.
  - Next: Up=7, Down=2, Swapped=1.
  - Following cycles continue counting normally with no further swap.
- Swap with Enable=0: Up=4, Down=5, Swap pulse.
  - Next: Up=5, Down=4, Swapped toggles, values then hold.
- Priority: Clear, Load(LoadValue=12) and a Swap edge in the same cycle.
  - Result: Up=0, Down=9, Swapped unchanged.
  - Next cycle Load alone with LoadValue=12: both counters = 9 (clamped).
- Non-unit step: STEP=3, MAX_COUNT=9, from reset Enable=1.
  - Up: 3,6,9,2 (WrapUp on 9->2).
  - Down: 6,3,0,7 (WrapDown on 0->7).
- Reset interplay: Swap held high while ResetN asserted and released → no swap on release, Swapped=0. Separately, ResetN low mid-count → Up=0, Down=9 next edge.

Source files
------------

// File: rtl/updown_count_pair.sv
// Purpose: pair of modulo counters, one counting up and one down, with swap/load/clear and wrap pulses.
// Latency: every output is registered and updates one Clock edge after its inputs are sampled.
// Backpressure: none; the counters advance on every cycle that Enable is high.
module updown_count_pair #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int STEP      = 1
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Enable,
    input  logic             Swap,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] UpCountS,
    output logic [WIDTH-1:0] DownCountS,
    output logic             WrapUp,
    output logic             WrapDown,
    output logic             Swapped
);

    // Extended-width constants, used only for the wrap comparison on increment.
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

    // Counter-width constants. The modulus truncates to 0 when MAX_COUNT is
    // 2^WIDTH-1, which is still correct because the final result always fits
    // in WIDTH bits and the subtraction wraps naturally at 2^WIDTH.
    localparam logic [WIDTH-1:0] MAX_L  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] STEP_L = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MOD_L  = WIDTH'(MAX_COUNT + 1);

    // Returns {wrapped, next value} for a modulo increment by STEP.
    function automatic logic [WIDTH:0] inc_f(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] sum_x;
        logic           wrap;
        sum_x = {1'b0, x} + STEP_X;
        wrap  = (sum_x > MAX_X);
        return {wrap, (wrap ? (x + STEP_L - MOD_L) : (x + STEP_L))};
    endfunction

    // Returns {wrapped, next value} for a modulo decrement by STEP.
    function automatic logic [WIDTH:0] dec_f(input logic [WIDTH-1:0] x);
        logic wrap;
        wrap = (x < STEP_L);
        return {wrap, (wrap ? (x + MOD_L - STEP_L) : (x - STEP_L))};
    endfunction

    logic             swap_q;
    logic             swap_edge;
    logic [WIDTH:0]   up_inc;
    logic [WIDTH:0]   up_dec;
    logic [WIDTH:0]   dn_inc;
    logic [WIDTH:0]   dn_dec;
    logic [WIDTH-1:0] load_clamped;

    // Candidate next values for every branch, plus the swap edge and clamped load value.
    always_comb begin
        swap_edge    = Swap & ~swap_q;
        up_inc       = inc_f(UpCountS);
        up_dec       = dec_f(UpCountS);
        dn_inc       = inc_f(DownCountS);
        dn_dec       = dec_f(DownCountS);
        load_clamped = (LoadValue > MAX_L) ? MAX_L : LoadValue;
    end

    // Counter state, with priority reset > clear > load > swap > count > hold; wrap flags pulse for one cycle.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            UpCountS   <= '0;
            DownCountS <= MAX_L;
            WrapUp     <= 1'b0;
            WrapDown   <= 1'b0;
            Swapped    <= 1'b0;
            // Pretend Swap was high so a Swap held across reset release is not an edge.
            swap_q     <= 1'b1;
        end else begin
            swap_q   <= Swap;
            WrapUp   <= 1'b0;
            WrapDown <= 1'b0;
            if (Clear) begin
                UpCountS   <= '0;
                DownCountS <= MAX_L;
            end else if (Load) begin
                UpCountS   <= load_clamped;
                DownCountS <= load_clamped;
            end else if (swap_edge) begin
                Swapped <= ~Swapped;
                if (Enable) begin
                    UpCountS   <= dn_inc[WIDTH-1:0];
                    DownCountS <= up_dec[WIDTH-1:0];
                    WrapUp     <= dn_inc[WIDTH];
                    WrapDown   <= up_dec[WIDTH];
                end else begin
                    UpCountS   <= DownCountS;
                    DownCountS <= UpCountS;
                end
            end else if (Enable) begin
                UpCountS   <= up_inc[WIDTH-1:0];
                DownCountS <= dn_dec[WIDTH-1:0];
                WrapUp     <= up_inc[WIDTH];
                WrapDown   <= dn_dec[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_updown_count_pair.sv
// Bench for updown_count_pair: directed table, hand-written STEP=3 sequence, randomized run against a model.
// Two instances share inputs: MAX_COUNT=9 with STEP=1 and with STEP=3.
// Outputs are sampled 1 time unit after each rising edge.
module tb_updown_count_pair;

    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       Enable = 1'b0;
    logic       Swap = 1'b0;
    logic       Clear = 1'b0;
    logic       Load = 1'b0;
    logic [3:0] LoadValue = 4'd0;

    logic [3:0] up1, dn1, up3, dn3;
    logic       wu1, wd1, sw1, wu3, wd3, sw3;

    int n_pass = 0;
    int n_total = 0;

    always #5 Clock = ~Clock;

    updown_count_pair #(.WIDTH(4), .MAX_COUNT(9), .STEP(1)) dut1 (
        .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Swap(Swap), .Clear(Clear),
        .Load(Load), .LoadValue(LoadValue), .UpCountS(up1), .DownCountS(dn1),
        .WrapUp(wu1), .WrapDown(wd1), .Swapped(sw1)
    );

    updown_count_pair #(.WIDTH(4), .MAX_COUNT(9), .STEP(3)) dut3 (
        .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Swap(Swap), .Clear(Clear),
        .Load(Load), .LoadValue(LoadValue), .UpCountS(up3), .DownCountS(dn3),
        .WrapUp(wu3), .WrapDown(wd3), .Swapped(sw3)
    );

    // Behavioural reference: index 0 is STEP=1, index 1 is STEP=3, modulus 10.
    int m_up[2];
    int m_dn[2];
    int m_wu[2];
    int m_wd[2];
    int m_sw[2];
    int m_prev_swap = 1;

    task automatic model_step();
        int steps[2];
        bit edge_seen;
        int old_up, old_dn, lv;
        steps[0] = 1;
        steps[1] = 3;
        edge_seen = Swap && (m_prev_swap == 0);
        for (int k = 0; k < 2; k++) begin
            if (!ResetN) begin
                m_up[k] = 0; m_dn[k] = 9; m_wu[k] = 0; m_wd[k] = 0; m_sw[k] = 0;
            end else begin
                m_wu[k] = 0;
                m_wd[k] = 0;
                old_up = m_up[k];
                old_dn = m_dn[k];
                if (Clear) begin
                    m_up[k] = 0;
                    m_dn[k] = 9;
                end else if (Load) begin
                    lv = int'(LoadValue);
                    m_up[k] = (lv > 9) ? 9 : lv;
                    m_dn[k] = m_up[k];
                end else if (edge_seen) begin
                    m_sw[k] = 1 - m_sw[k];
                    if (Enable) begin
                        m_up[k] = (old_dn + steps[k]) % 10;
                        m_wu[k] = (old_dn + steps[k] >= 10) ? 1 : 0;
                        m_dn[k] = (old_up - steps[k] + 10) % 10;
                        m_wd[k] = (old_up < steps[k]) ? 1 : 0;
                    end else begin
                        m_up[k] = old_dn;
                        m_dn[k] = old_up;
                    end
                end else if (Enable) begin
                    m_up[k] = (old_up + steps[k]) % 10;
                    m_wu[k] = (old_up + steps[k] >= 10) ? 1 : 0;
                    m_dn[k] = (old_dn - steps[k] + 10) % 10;
                    m_wd[k] = (old_dn < steps[k]) ? 1 : 0;
                end
            end
        end
        m_prev_swap = (!ResetN) ? 1 : int'(Swap);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic apply(input bit rstn, input bit en, input bit swp, input bit clr,
                         input bit ld, input logic [3:0] lv);
        ResetN = rstn; Enable = en; Swap = swp; Clear = clr; Load = ld; LoadValue = lv;
        model_step();
        @(posedge Clock);
        #1;
    endtask

    typedef struct {
        bit rstn, en, swp, clr, ld;
        logic [3:0] lv;
        int up, dn, wu, wd, sw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input bit rstn, input bit en, input bit swp, input bit clr,
                               input bit ld, input int lv, input int up, input int dn,
                               input int wu, input int wd, input int sw);
        vec_t r;
        r.rstn = rstn; r.en = en; r.swp = swp; r.clr = clr; r.ld = ld; r.lv = 4'(lv);
        r.up = up; r.dn = dn; r.wu = wu; r.wd = wd; r.sw = sw;
        return r;
    endfunction

    initial begin
        int exp_u3[4];
        int exp_d3[4];
        int exp_w3[4];

        //                 rstn en swp clr ld lv  up dn wu wd sw
        tbl.push_back(v(0, 0, 0, 0, 0, 0,   0, 9, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,   0, 9, 0, 0, 0));
        for (int i = 1; i <= 9; i++)
            tbl.push_back(v(1, 1, 0, 0, 0, 0, i, 9 - i, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0,   0, 9, 1, 1, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0,   1, 8, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0,   2, 7, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0,   3, 6, 0, 0, 0));
        // Swap with Enable, Swap held for 5 cycles: one swap only.
        tbl.push_back(v(1, 1, 1, 0, 0, 0,   7, 2, 0, 0, 1));
        tbl.push_back(v(1, 1, 1, 0, 0, 0,   8, 1, 0, 0, 1));
        tbl.push_back(v(1, 1, 1, 0, 0, 0,   9, 0, 0, 0, 1));
        tbl.push_back(v(1, 1, 1, 0, 0, 0,   0, 9, 1, 1, 1));
        tbl.push_back(v(1, 1, 1, 0, 0, 0,   1, 8, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   1, 8, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 0,   2, 7, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 0,   3, 6, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 0,   4, 5, 0, 0, 1));
        // Swap with Enable=0, then hold.
        tbl.push_back(v(1, 0, 1, 0, 0, 0,   5, 4, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   5, 4, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 0,   4, 5, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   4, 5, 0, 0, 1));
        // Clear beats Load and Swap edge; then clamped Load.
        tbl.push_back(v(1, 1, 1, 1, 1, 12,  0, 9, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 1, 12,  9, 9, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 0,   0, 8, 1, 0, 1));
        // Reset mid-count, then Swap held across reset release.
        tbl.push_back(v(0, 1, 0, 0, 0, 0,   0, 9, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0,   0, 9, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 0,   0, 9, 0, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 0, 0,   1, 8, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,   1, 8, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 0,   8, 1, 0, 0, 1));

        foreach (tbl[i]) begin
            apply(tbl[i].rstn, tbl[i].en, tbl[i].swp, tbl[i].clr, tbl[i].ld, tbl[i].lv);
            chk($sformatf("row%0d_up", i), int'(up1), tbl[i].up);
            chk($sformatf("row%0d_down", i), int'(dn1), tbl[i].dn);
            chk($sformatf("row%0d_wrapup", i), int'(wu1), tbl[i].wu);
            chk($sformatf("row%0d_wrapdown", i), int'(wd1), tbl[i].wd);
            chk($sformatf("row%0d_swapped", i), int'(sw1), tbl[i].sw);
        end

        // STEP=3 instance from reset.
        exp_u3 = '{3, 6, 9, 2};
        exp_d3 = '{6, 3, 0, 7};
        exp_w3 = '{0, 0, 0, 1};
        apply(0, 0, 0, 0, 0, 4'd0);
        chk("step3_reset_up", int'(up3), 0);
        chk("step3_reset_down", int'(dn3), 9);
        for (int i = 0; i < 4; i++) begin
            apply(1, 1, 0, 0, 0, 4'd0);
            chk($sformatf("step3_up%0d", i), int'(up3), exp_u3[i]);
            chk($sformatf("step3_down%0d", i), int'(dn3), exp_d3[i]);
            chk($sformatf("step3_wrapup%0d", i), int'(wu3), exp_w3[i]);
            chk($sformatf("step3_wrapdown%0d", i), int'(wd3), exp_w3[i]);
        end

        // Randomized run against the reference model, both instances.
        for (int c = 0; c < 400; c++) begin
            apply(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
            chk($sformatf("rand%0d_s1_state", c),
                ((int'(up1) * 10 + int'(dn1)) * 8) + int'(wu1) * 4 + int'(wd1) * 2 + int'(sw1),
                ((m_up[0] * 10 + m_dn[0]) * 8) + m_wu[0] * 4 + m_wd[0] * 2 + m_sw[0]);
            chk($sformatf("rand%0d_s3_state", c),
                ((int'(up3) * 10 + int'(dn3)) * 8) + int'(wu3) * 4 + int'(wd3) * 2 + int'(sw3),
                ((m_up[1] * 10 + m_dn[1]) * 8) + m_wu[1] * 4 + m_wd[1] * 2 + m_sw[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
